// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester and memory signals shared by dmem_arbiter
interface dmem_arbiter_if #(
  parameter int ADDR_W = 14
);
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [31:0]       p0_wdata;
  logic [3:0]        p0_wmask;
  logic              p0_gnt;
  logic              p0_rvalid;
  logic [31:0]       p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [31:0]       p1_wdata;
  logic [3:0]        p1_wmask;
  logic              p1_gnt;
  logic              p1_rvalid;
  logic [31:0]       p1_rdata;

  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  // Arbiter side: takes requests and memory read data, drives grants and the memory bus.
  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata, p0_wmask,
    input  p1_req, p1_we, p1_addr, p1_wdata, p1_wmask,
    input  mem_rdata,
    output p0_gnt, p0_rvalid, p0_rdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  // Environment side: the two requesters plus the memory itself.
  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata, p0_wmask,
    output p1_req, p1_we, p1_addr, p1_wdata, p1_wmask,
    output mem_rdata,
    input  p0_gnt, p0_rvalid, p0_rdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data-memory arbiter, port 0 priority with port 1 starvation guard
module dmem_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus
);
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0]        r_wait_cnt;
  logic              r_rsp_pend;
  logic              r_rsp_port;

  logic              w_force1;
  logic              w_p0_gnt;
  logic              w_p1_gnt;
  logic              w_gnt;
  logic              w_we;
  logic [3:0]        w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [31:0]       w_mem_wdata;

  assign w_force1 = (r_wait_cnt == LIMIT);

  // Grants are held off for the whole reset window so nothing reaches memory.
  always_comb begin
    w_p0_gnt = 1'b0;
    w_p1_gnt = 1'b0;
    if (!rst) begin
      if (w_force1 && bus.p1_req) begin
        w_p1_gnt = 1'b1;
      end else if (bus.p0_req) begin
        w_p0_gnt = 1'b1;
      end else if (bus.p1_req) begin
        w_p1_gnt = 1'b1;
      end
    end
  end

  assign w_gnt = w_p0_gnt | w_p1_gnt;

  always_comb begin
    w_we        = 1'b0;
    w_mem_we    = 4'b0000;
    w_mem_addr  = '0;
    w_mem_wdata = 32'h0;
    if (w_p1_gnt) begin
      w_we        = bus.p1_we;
      w_mem_we    = bus.p1_we ? bus.p1_wmask : 4'b0000;
      w_mem_addr  = bus.p1_addr;
      w_mem_wdata = bus.p1_wdata;
    end else if (w_p0_gnt) begin
      w_we        = bus.p0_we;
      w_mem_we    = bus.p0_we ? bus.p0_wmask : 4'b0000;
      w_mem_addr  = bus.p0_addr;
      w_mem_wdata = bus.p0_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= 8'd0;
      r_rsp_pend <= 1'b0;
      r_rsp_port <= 1'b0;
    end else begin
      r_rsp_pend <= w_gnt & ~w_we;
      r_rsp_port <= w_p1_gnt;
      // A withdrawn request forfeits its accumulated wait.
      if (!bus.p1_req || w_p1_gnt) begin
        r_wait_cnt <= 8'd0;
      end else if (r_wait_cnt != LIMIT) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end
    end
  end

  assign bus.p0_gnt    = w_p0_gnt;
  assign bus.p1_gnt    = w_p1_gnt;
  // Masked by rst so a read in flight when reset hits never reports.
  assign bus.p0_rvalid = r_rsp_pend & ~r_rsp_port & ~rst;
  assign bus.p1_rvalid = r_rsp_pend &  r_rsp_port & ~rst;
  assign bus.p0_rdata  = bus.mem_rdata;
  assign bus.p1_rdata  = bus.mem_rdata;

  assign bus.mem_en    = w_gnt;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;

  a_one_gnt: assert property (@(posedge clk) !(w_p0_gnt && w_p1_gnt));
  a_cnt_bound: assert property (@(posedge clk) r_wait_cnt <= LIMIT);
endmodule
